// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory. Registered fetch path with a stall hold,
// a program-load port, and alignment/range error flagging.
module instr_mem_sync #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADD_WIDTH  = 32,
   parameter int                    DEPTH      = 128,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_en,
   input  logic [ADD_WIDTH-1:0]  load_addr,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  req,
   input  logic [ADD_WIDTH-1:0]  pc_in,
   input  logic                  stall,
   output logic [DATA_WIDTH-1:0] ins_out,
   output logic                  ins_valid,
   output logic                  addr_err,
   output logic                  busy
);

   localparam int IDXW = ADD_WIDTH - 2;
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDXW-1:0] DEPTH_IDX = IDXW'(DEPTH);

   typedef enum logic {RUN, LOAD} state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_ins;
   logic                  r_valid;
   logic                  r_err;

   logic [IDXW-1:0] w_ld_idx;
   logic [IDXW-1:0] w_pc_idx;
   logic            w_ld_ok;
   logic            w_pc_ok;
   logic            w_accept;

   // Range check uses the full word index so that high address bits and
   // non-power-of-two depths both flag as out of range.
   assign w_ld_idx = load_addr[ADD_WIDTH-1:2];
   assign w_pc_idx = pc_in[ADD_WIDTH-1:2];
   assign w_ld_ok  = (load_addr[1:0] == 2'b00) && (w_ld_idx < DEPTH_IDX);
   assign w_pc_ok  = (pc_in[1:0] == 2'b00) && (w_pc_idx < DEPTH_IDX);
   assign w_accept = req && !stall && !load_en && (r_state == RUN);

   // Memory is not reset; program contents survive a core reset.
   always_ff @(posedge clk) begin
      if (load_en && w_ld_ok)
         r_mem[w_ld_idx[AW-1:0]] <= load_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
         r_ins   <= NOP_WORD;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= load_en ? LOAD : RUN;
         if (!stall) begin
            if (w_accept) begin
               r_ins   <= w_pc_ok ? r_mem[w_pc_idx[AW-1:0]] : NOP_WORD;
               r_valid <= 1'b1;
               r_err   <= !w_pc_ok;
            end else begin
               r_ins   <= NOP_WORD;
               r_valid <= 1'b0;
               r_err   <= 1'b0;
            end
         end
      end
   end

   assign ins_out   = r_ins;
   assign ins_valid = r_valid;
   assign addr_err  = r_err;
   assign busy      = (r_state == LOAD);

endmodule

// File: tb/tb_instr_mem_sync.sv
// Bench for instr_mem_sync: directed vector table, reset-in-flight sequence,
// then randomized traffic against a word-array reference model.
module tb_instr_mem_sync;

   localparam int DEPTH = 128;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_en;
   logic [31:0] load_addr;
   logic [31:0] load_data;
   logic        req;
   logic [31:0] pc_in;
   logic        stall;
   logic [31:0] ins_out;
   logic        ins_valid;
   logic        addr_err;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;

   instr_mem_sync #(.DATA_WIDTH(32), .ADD_WIDTH(32), .DEPTH(DEPTH), .NOP_WORD(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .req(req), .pc_in(pc_in), .stall(stall),
      .ins_out(ins_out), .ins_valid(ins_valid), .addr_err(addr_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        ld;
      bit [31:0] la;
      bit [31:0] ldat;
      bit        rq;
      bit [31:0] pc;
      bit        st;
      bit [31:0] e_ins;
      bit        e_v;
      bit        e_err;
      bit        e_busy;
   } vec_t;

   vec_t tbl[$];

   // reference model state
   bit [31:0] m_mem   [DEPTH];
   bit        m_known [DEPTH];
   bit [31:0] m_ins;
   bit        m_ins_known;
   bit        m_v, m_err, m_busy;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit ld, input bit [31:0] la, input bit [31:0] ldat,
                        input bit rq, input bit [31:0] pc, input bit st);
      load_en = ld; load_addr = la; load_data = ldat;
      req = rq; pc_in = pc; st_set(st);
   endtask

   task automatic st_set(input bit st);
      stall = st;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit [31:0] rand_addr();
      bit [31:0] a;
      a = $urandom_range(0, DEPTH + 7) * 4;
      if ($urandom_range(0, 7) == 0) a = a + $urandom_range(1, 3);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      return a;
   endfunction

   // One clock edge of behaviour, computed from the addressing rules.
   task automatic model_step(input bit ld, input bit [31:0] la, input bit [31:0] ldat,
                             input bit rq, input bit [31:0] pc, input bit st);
      int unsigned idx;
      bit ok, acc;
      acc = rq && !st && !ld && !m_busy;
      if (!st) begin
         if (acc) begin
            idx = pc >> 2;
            ok  = (pc % 4 == 0) && (idx < DEPTH);
            m_v = 1; m_err = !ok;
            if (ok) begin m_ins = m_mem[idx]; m_ins_known = m_known[idx]; end
            else begin m_ins = 0; m_ins_known = 1; end
         end else begin
            m_v = 0; m_err = 0; m_ins = 0; m_ins_known = 1;
         end
      end
      if (ld) begin
         idx = la >> 2;
         if (la % 4 == 0 && idx < DEPTH) begin m_mem[idx] = ldat; m_known[idx] = 1; end
      end
      m_busy = ld;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      #12;
      chk("reset ins_out", ins_out, 32'h0);
      chk("reset ins_valid", 32'(ins_valid), 32'h0);
      chk("reset addr_err", 32'(addr_err), 32'h0);
      chk("reset busy", 32'(busy), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      //               ld la          ldat          rq pc          st ins           v  e  busy
      tbl.push_back('{1, 32'h0,    32'hAAAA0001, 0, 32'h0,   0, 32'h0,        0, 0, 1});
      tbl.push_back('{1, 32'h4,    32'hAAAA0002, 0, 32'h0,   0, 32'h0,        0, 0, 1});
      tbl.push_back('{1, 32'h10,   32'hAAAA0005, 0, 32'h0,   0, 32'h0,        0, 0, 1});
      tbl.push_back('{0, 32'h0,    32'h0,        1, 32'h0,   0, 32'h0,        0, 0, 0});
      tbl.push_back('{0, 32'h0,    32'h0,        1, 32'h0,   0, 32'hAAAA0001, 1, 0, 0});
      tbl.push_back('{0, 32'h0,    32'h0,        1, 32'h4,   0, 32'hAAAA0002, 1, 0, 0});
      tbl.push_back('{0, 32'h0,    32'h0,        1, 32'h10,  0, 32'hAAAA0005, 1, 0, 0});
      tbl.push_back('{0, 32'h0,    32'h0,        1, 32'h6,   0, 32'h0,        1, 1, 0});
      tbl.push_back('{0, 32'h0,    32'h0,        1, 32'h200, 0, 32'h0,        1, 1, 0});
      tbl.push_back('{0, 32'h0,    32'h0,        1, 32'h4,   0, 32'hAAAA0002, 1, 0, 0});
      tbl.push_back('{0, 32'h0,    32'h0,        1, 32'h10,  1, 32'hAAAA0002, 1, 0, 0});
      tbl.push_back('{0, 32'h0,    32'h0,        1, 32'h10,  1, 32'hAAAA0002, 1, 0, 0});
      tbl.push_back('{0, 32'h0,    32'h0,        1, 32'h10,  1, 32'hAAAA0002, 1, 0, 0});
      tbl.push_back('{0, 32'h0,    32'h0,        1, 32'h10,  0, 32'hAAAA0005, 1, 0, 0});
      tbl.push_back('{0, 32'h0,    32'h0,        0, 32'h0,   0, 32'h0,        0, 0, 0});
      tbl.push_back('{1, 32'h0,    32'hDEADBEEF, 1, 32'h0,   0, 32'h0,        0, 0, 1});
      tbl.push_back('{0, 32'h0,    32'h0,        0, 32'h0,   0, 32'h0,        0, 0, 0});
      tbl.push_back('{0, 32'h0,    32'h0,        1, 32'h0,   0, 32'hDEADBEEF, 1, 0, 0});
      tbl.push_back('{1, 32'h3,    32'h11111111, 0, 32'h0,   0, 32'h0,        0, 0, 1});
      tbl.push_back('{1, 32'h400,  32'h22222222, 0, 32'h0,   0, 32'h0,        0, 0, 1});
      tbl.push_back('{0, 32'h0,    32'h0,        0, 32'h0,   0, 32'h0,        0, 0, 0});
      tbl.push_back('{0, 32'h0,    32'h0,        1, 32'h0,   0, 32'hDEADBEEF, 1, 0, 0});
      tbl.push_back('{0, 32'h0,    32'h0,        1, 32'h4,   0, 32'hAAAA0002, 1, 0, 0});

      foreach (tbl[i]) begin
         drive(tbl[i].ld, tbl[i].la, tbl[i].ldat, tbl[i].rq, tbl[i].pc, tbl[i].st);
         tick();
         chk($sformatf("row%0d ins_out", i), ins_out, tbl[i].e_ins);
         chk($sformatf("row%0d ins_valid", i), 32'(ins_valid), 32'(tbl[i].e_v));
         chk($sformatf("row%0d addr_err", i), 32'(addr_err), 32'(tbl[i].e_err));
         chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      end

      // Reset with a valid response held by stall and a load in progress.
      drive(0, 0, 0, 1, 32'h0, 0);
      tick();
      drive(1, 32'h8, 32'h12345678, 0, 32'h0, 1);
      tick();
      chk("pre-reset ins_valid", 32'(ins_valid), 32'h1);
      chk("pre-reset busy", 32'(busy), 32'h1);
      drive(0, 0, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset ins_out", ins_out, 32'h0);
      chk("async reset ins_valid", 32'(ins_valid), 32'h0);
      chk("async reset busy", 32'(busy), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 1, 32'h0, 0);
      tick();
      chk("post-reset fetch 0x0", ins_out, 32'hDEADBEEF);
      chk("post-reset ins_valid", 32'(ins_valid), 32'h1);
      drive(0, 0, 0, 1, 32'h8, 0);
      tick();
      chk("load during stall 0x8", ins_out, 32'h12345678);

      // Random traffic from a fresh reset; model seeded with known contents.
      drive(0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #3;
      @(negedge clk);
      rst_n = 1'b1;
      m_mem[0] = 32'hDEADBEEF;  m_known[0] = 1;
      m_mem[1] = 32'hAAAA0002;  m_known[1] = 1;
      m_mem[2] = 32'h12345678;  m_known[2] = 1;
      m_mem[4] = 32'hAAAA0005;  m_known[4] = 1;
      m_ins = 0; m_ins_known = 1; m_v = 0; m_err = 0; m_busy = 0;
      for (int c = 0; c < 500; c++) begin
         bit        ld, rq, st;
         bit [31:0] la, ldat, pc;
         ld   = ($urandom_range(0, 5) == 0);
         la   = rand_addr();
         ldat = $urandom;
         rq   = ($urandom_range(0, 3) != 0);
         pc   = rand_addr();
         st   = ($urandom_range(0, 4) == 0);
         drive(ld, la, ldat, rq, pc, st);
         model_step(ld, la, ldat, rq, pc, st);
         tick();
         if (m_ins_known) chk($sformatf("rnd%0d ins_out", c), ins_out, m_ins);
         chk($sformatf("rnd%0d ins_valid", c), 32'(ins_valid), 32'(m_v));
         chk($sformatf("rnd%0d addr_err", c), 32'(addr_err), 32'(m_err));
         chk($sformatf("rnd%0d busy", c), 32'(busy), 32'(m_busy));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
